xfeed_ctrl: RTL

XFEED_CTRL -- requirements
Module: xfeed_ctrl

---
 rtl/xfeed_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/xfeed_ctrl.sv
// Streams one image of WORDS_PER_IMG words from the input memory to the
// systolic accelerator over a valid/ready link, with abort and bad-index error.
module xfeed_ctrl #(
  parameter int unsigned WORDS_PER_IMG = 196,
  parameter int unsigned NUM_IMG       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  img_idx,
  input  logic        abort,
  output logic [31:0] ctr1,
  input  logic [31:0] xdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  localparam logic [31:0] WPI  = 32'(WORDS_PER_IMG);
  localparam logic [31:0] NIMG = 32'(NUM_IMG);

  state_t      state, state_nx;
  logic [31:0] base, base_nx;
  logic [31:0] word_cnt, cnt_nx;
  logic [31:0] data_nx;
  logic        valid_nx;
  logic        err_nx;
  logic [31:0] idx_w;

  assign idx_w = {24'd0, img_idx};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      word_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      base      <= base_nx;
      word_cnt  <= cnt_nx;
      out_data  <= data_nx;
      out_valid <= valid_nx;
      err       <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    base_nx  = base;
    cnt_nx   = word_cnt;
    data_nx  = out_data;
    valid_nx = out_valid;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (idx_w < NIMG) begin
            base_nx  = idx_w * WPI;
            cnt_nx   = '0;
            state_nx = LOAD;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end else begin
          data_nx  = xdata;
          valid_nx = 1'b1;
          cnt_nx   = 32'd1;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        // abort wins over a handshake presented in the same cycle
        if (abort) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end else if (out_valid && out_ready) begin
          if (word_cnt < WPI) begin
            data_nx = xdata;
            cnt_nx  = word_cnt + 32'd1;
          end else begin
            valid_nx = 1'b0;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign ctr1     = base + word_cnt;
  assign busy     = (state == LOAD) || (state == STREAM);
  assign done     = (state == DONE);
  assign out_last = out_valid && (word_cnt == WPI);

endmodule
